// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: splits a serial MSB-first stream framed by sync
// into a channel A word followed by a channel B word, each WIDTH bits wide.
module tdm_demux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             in_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic             A_valid,
    output logic             B_valid,
    output logic             S,
    output logic             busy,
    output logic             frame_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV_A = 2'd1,
        RECV_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] a_out_q, b_out_q;
    logic             a_valid_q, b_valid_q, frame_err_q;
    logic             a_load, b_load, resync_err;

    assign shifted = {shift_q[WIDTH-2:0], din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A sync beat always restarts the frame, taking priority even over a slot's last bit.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shift_d    = shift_q;
        a_load     = 1'b0;
        b_load     = 1'b0;
        resync_err = 1'b0;
        if (in_valid) begin
            if (sync) begin
                state_d    = RECV_A;
                count_d    = CW'(1);
                shift_d    = {{(WIDTH-1){1'b0}}, din};
                resync_err = (state_q != IDLE);
            end else begin
                case (state_q)
                    RECV_A: begin
                        shift_d = shifted;
                        if (count_q == LAST) begin
                            a_load  = 1'b1;
                            count_d = '0;
                            state_d = RECV_B;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                    RECV_B: begin
                        shift_d = shifted;
                        if (count_q == LAST) begin
                            b_load  = 1'b1;
                            count_d = '0;
                            state_d = IDLE;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        S    = (state_q == RECV_B);
        busy = (state_q == RECV_A) || (state_q == RECV_B);
    end

    // Valid and error flags are registered so each pulse lands in the cycle after its beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            shift_q     <= '0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            shift_q     <= shift_d;
            a_valid_q   <= a_load;
            b_valid_q   <= b_load;
            frame_err_q <= resync_err;
            if (a_load) begin
                a_out_q <= shifted;
            end
            if (b_load) begin
                b_out_q <= shifted;
            end
        end
    end

    assign A_out     = a_out_q;
    assign B_out     = b_out_q;
    assign A_valid   = a_valid_q;
    assign B_valid   = b_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed bench for tdm_demux2: frames are expanded into per-beat vectors with
// expected outputs, then replayed and compared after every clock edge.
module tb_tdm_demux2;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       in_valid;
    logic       sync;
    logic [7:0] A_out;
    logic [7:0] B_out;
    logic       A_valid;
    logic       B_valid;
    logic       S;
    logic       busy;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] curA = 8'h00;
    logic [7:0] curB = 8'h00;

    typedef struct {
        logic       din;
        logic       sync;
        logic       inValid;
        logic [7:0] expA;
        logic [7:0] expB;
        logic       expAV;
        logic       expBV;
        logic       expS;
        logic       expBusy;
        logic       expErr;
        string      name;
    } vec_t;

    vec_t vecs[$];

    tdm_demux2 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .in_valid  (in_valid),
        .sync      (sync),
        .A_out     (A_out),
        .B_out     (B_out),
        .A_valid   (A_valid),
        .B_valid   (B_valid),
        .S         (S),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [20:0] expv);
        logic [20:0] got;
        got = {A_out, B_out, A_valid, B_valid, S, busy, frame_err};
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got A=%h B=%h Av=%b Bv=%b S=%b busy=%b err=%b, expected A=%h B=%h Av=%b Bv=%b S=%b busy=%b err=%b",
                     name, got[20:13], got[12:5], got[4], got[3], got[2], got[1], got[0],
                     expv[20:13], expv[12:5], expv[4], expv[3], expv[2], expv[1], expv[0]);
        end
    endtask

    task automatic addVec(input logic d, input logic sy, input logic iv,
                          input logic av, input logic bv, input logic s,
                          input logic bz, input logic er, input string name);
        vec_t v;
        v.din = d; v.sync = sy; v.inValid = iv;
        v.expA = curA; v.expB = curB;
        v.expAV = av; v.expBV = bv; v.expS = s; v.expBusy = bz; v.expErr = er;
        v.name = name;
        vecs.push_back(v);
    endtask

    // Expected timing: A_out/A_valid after beat 8, S high after beats 8..15, frame ends after beat 16.
    task automatic addFrame(input logic [7:0] a, input logic [7:0] b, input int nBeats,
                            input int stallAfter, input int stallLen,
                            input logic errFirst, input string tag);
        logic bitv;
        for (int n = 1; n <= nBeats; n++) begin
            bitv = (n <= 8) ? a[8-n] : b[16-n];
            if (n == 8) curA = a;
            if (n == 16) curB = b;
            addVec(bitv, n == 1, 1'b1, n == 8, n == 16, (n >= 8 && n < 16), n < 16,
                   errFirst && (n == 1), $sformatf("%s beat%0d", tag, n));
            if (n == stallAfter) begin
                for (int s = 0; s < stallLen; s++) begin
                    addVec(~bitv, 1'b1, 1'b0, 1'b0, 1'b0, (n >= 8 && n < 16), n < 16, 1'b0,
                           $sformatf("%s stall%0d", tag, s));
                end
            end
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            din      = vecs[i].din;
            sync     = vecs[i].sync;
            in_valid = vecs[i].inValid;
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, {vecs[i].expA, vecs[i].expB, vecs[i].expAV,
                                       vecs[i].expBV, vecs[i].expS, vecs[i].expBusy,
                                       vecs[i].expErr});
        end
        vecs.delete();
        in_valid = 1'b0;
        sync     = 1'b0;
        din      = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        din      = 1'b0;
        in_valid = 1'b0;
        sync     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset state", 21'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain frame, stalled frame, resync in B, resync on A's last bit, back-to-back frames.
        addFrame(8'hA5, 8'h3C, 16, 0, 0, 1'b0, "basic");
        addFrame(8'hA5, 8'h3C, 16, 4, 3, 1'b0, "stall");
        addFrame(8'h5A, 8'h00, 12, 0, 0, 1'b0, "partialB");
        addFrame(8'h0F, 8'hF0, 16, 0, 0, 1'b1, "resyncB");
        addFrame(8'h77, 8'h00, 7, 0, 0, 1'b0, "partialA");
        addFrame(8'h12, 8'h34, 16, 0, 0, 1'b1, "resyncAlast");
        addFrame(8'h11, 8'h22, 16, 0, 0, 1'b0, "b2b1");
        addFrame(8'h33, 8'h44, 16, 0, 0, 1'b0, "b2b2");
        addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle nosync1");
        addVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle nosync2");
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle stalled sync");
        addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle nosync3");
        applyStimulus();

        // Asynchronous reset in the middle of channel A, checked before any clock edge.
        addFrame(8'hE7, 8'h00, 3, 0, 0, 1'b0, "prerst");
        applyStimulus();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset mid A", 21'h0);
        curA = 8'h00;
        curB = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            addVec(i[0], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("postrst nosync%0d", i));
        end
        addFrame(8'hC3, 8'h96, 16, 0, 0, 1'b0, "postrst");
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux2.md
TDM_DEMUX2 -- requirements
Module: tdm_demux2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bits per channel slot (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port din, input, 1 bit: serial TDM data, MSB first, channel A slot then channel B slot.
REQ-005 The block SHALL have port in_valid, input, 1 bit: din and sync are sampled only when in_valid=1.
REQ-006 The block SHALL have port sync, input, 1 bit: frame start; marks the cycle carrying bit WIDTH-1 of channel A.
REQ-007 The block SHALL have port A_out, output, WIDTH bits: last complete channel A word.
REQ-008 The block SHALL have port B_out, output, WIDTH bits: last complete channel B word.
REQ-009 The block SHALL have port A_valid, output, 1 bit: one-cycle pulse when A_out updates.
REQ-010 The block SHALL have port B_valid, output, 1 bit: one-cycle pulse when B_out updates.
REQ-011 The block SHALL have port S, output, 1 bit: current slot select, 0 = channel A (or idle), 1 = channel B.
REQ-012 The block SHALL have port busy, output, 1 bit: 1 while a frame is in progress.
REQ-013 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a resync mid-frame.

Function
REQ-014 The block SHALL implement states IDLE, RECV_A and RECV_B, held in registers.
REQ-015 A sampled beat SHALL be a rising edge with in_valid=1; edges with in_valid=0 SHALL change no state, counter or shift register (stall).
REQ-016 In IDLE, a beat with sync=1 SHALL load din as bit WIDTH-1, set bit count to 1 and enter RECV_A; beats with sync=0 SHALL be discarded.
REQ-017 In RECV_A and RECV_B, each beat with sync=0 SHALL shift din in at the LSB and increment the bit count.
REQ-018 On the beat completing the WIDTH-th A bit, A_out SHALL load the assembled word, A_valid SHALL be 1 for exactly the following cycle, the count SHALL clear, and the state SHALL go to RECV_B.
REQ-019 On the beat completing the WIDTH-th B bit, B_out SHALL load the word, B_valid SHALL pulse for one cycle, and the state SHALL return to IDLE.
REQ-020 Latency from the beat carrying a slot's last bit to the matching valid pulse SHALL be one edge: valid is visible in the cycle after that beat.
REQ-021 A beat with sync=1 in RECV_A or RECV_B, including on a slot's final bit, SHALL discard the partial word, pulse frame_err for one cycle, and restart as in REQ-016.
REQ-022 On a resync (REQ-021), A_out and B_out SHALL remain unchanged and no valid SHALL pulse.
REQ-023 A sync beat on the cycle immediately after B completes SHALL start a new frame with no gap and no frame_err.
REQ-024 S SHALL be 1 exactly while the state is RECV_B; busy SHALL be 1 while the state is RECV_A or RECV_B.
REQ-025 A_out and B_out SHALL hold their values indefinitely until the next valid completion.

Reset
REQ-026 Assertion of rst_n=0 SHALL immediately, with no clock required, set the state to IDLE and clear the count, the shift register, A_out, B_out, A_valid, B_valid, S, busy and frame_err to 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after rst_n rises, the first accepted beat SHALL be a sync beat.

Verification
REQ-028 The bench SHALL check: WIDTH=8, sync then 16 continuous beats carrying 0xA5, 0x3C -> A_out=0xA5 with A_valid pulse after beat 8, B_out=0x3C with B_valid pulse after beat 16, S=1 during beats 9-16.
REQ-029 The bench SHALL check: the same frame with in_valid=0 for 3 cycles after beat 4 -> identical words, with A_valid and B_valid each 3 cycles later.
REQ-030 The bench SHALL check: resync after 4 B bits, then frame 0x0F, 0xF0 -> frame_err single pulse, B_out stays 0x3C, then A_out=0x0F and B_out=0xF0.
REQ-031 The bench SHALL check: two back-to-back frames, 0x11/0x22 then 0x33/0x44 -> four valid pulses, no frame_err, final outputs 0x33/0x44.
REQ-032 The bench SHALL check: rst_n low asynchronously mid-RECV_A -> all outputs 0 before the next clk edge; non-sync beats after release produce no valid.
REQ-033 The bench SHALL check: beats without sync in IDLE, and sync with in_valid=0 -> busy stays 0, and no output changes.
